// File: rtl/mem_bus_arbiter.sv
// Two-master, round-robin arbiter in front of the memory-map master port.
// One transaction at a time: IDLE -> ACCESS -> RESP -> IDLE. Every bus-side
// output is a flop. Unmapped addresses are answered with an error response and
// never reach the slaves.
module mem_bus_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wd,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wd,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0] bus_wd,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [DATA_WIDTH-1:0] bus_rd,
  output logic [1:0]            grant
);

  localparam logic [ADDR_WIDTH-1:0] RomBase  = ADDR_WIDTH'(32'h0040_0000);
  localparam logic [ADDR_WIDTH-1:0] UartBase = ADDR_WIDTH'(32'h1001_0020);
  localparam logic [ADDR_WIDTH-1:0] UartEnd  = ADDR_WIDTH'(32'h1001_0040);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    last_q;       // index of the master granted most recently
  logic                    mapped_q;     // decode result of the transaction in flight
  logic [1:0]              grant_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [DATA_WIDTH-1:0]   bus_wd_q;
  logic                    bus_we_q, bus_re_q;
  logic                    m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m1_rdata_q;

  logic                    pick;         // 0 = m0 wins, 1 = m1 wins
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wd;
  logic                    sel_we;
  logic                    sel_mapped;
  logic                    start, end_access, end_resp;
  logic [DATA_WIDTH-1:0]   resp_data;

  // Winner selection, winner decode and next-state logic
  always_comb begin
    if (m0_req && m1_req) pick = ~last_q;
    else                  pick = m1_req;
    sel_addr   = pick ? m1_addr : m0_addr;
    sel_wd     = pick ? m1_wd   : m0_wd;
    sel_we     = pick ? m1_we   : m0_we;
    sel_mapped = ((sel_addr >= RomBase)  && (sel_addr < UartBase)) ||
                 ((sel_addr >= UartBase) && (sel_addr < UartEnd));
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (m0_req || m1_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Per-state control strobes and the response value captured at the end of ACCESS
  always_comb begin
    start      = (state_q == StIdle) && (m0_req || m1_req);
    end_access = (state_q == StAccess);
    end_resp   = (state_q == StResp);
    resp_data  = mapped_q ? bus_rd : '0;
  end

  // Grant, priority pointer and bus-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      mapped_q   <= 1'b0;
      grant_q    <= '0;
      bus_addr_q <= '0;
      bus_wd_q   <= '0;
      bus_we_q   <= 1'b0;
      bus_re_q   <= 1'b0;
    end else begin
      // Strobes can only rise on a grant, so they are high for the ACCESS cycle alone
      bus_we_q <= start & sel_mapped & sel_we;
      bus_re_q <= start & sel_mapped & ~sel_we;
      if (start) begin
        last_q   <= pick;
        mapped_q <= sel_mapped;
        grant_q  <= pick ? 2'b10 : 2'b01;
        if (sel_mapped) begin
          bus_addr_q <= sel_addr;
          bus_wd_q   <= sel_wd;
        end
      end else if (end_resp) begin
        grant_q <= '0;
      end
    end
  end

  // Master-side response registers; rdata holds until that master's next RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      m0_ack_q <= end_access & grant_q[0];
      m1_ack_q <= end_access & grant_q[1];
      m0_err_q <= end_access & grant_q[0] & ~mapped_q;
      m1_err_q <= end_access & grant_q[1] & ~mapped_q;
      if (end_access && grant_q[0]) m0_rdata_q <= resp_data;
      if (end_access && grant_q[1]) m1_rdata_q <= resp_data;
    end
  end

  assign grant       = grant_q;
  assign bus_address = bus_addr_q;
  assign bus_wd      = bus_wd_q;
  assign bus_we      = bus_we_q;
  assign bus_re      = bus_re_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_err      = m0_err_q;
  assign m1_err      = m1_err_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected bus strobes and
// responses; a negedge monitor pops and compares whenever the DUT shows a strobe
// or an ack.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wd = '0, m1_addr = '0, m1_wd = '0;
  logic [31:0] m0_rdata, m1_rdata, bus_address, bus_wd, bus_rd;
  logic        m0_ack, m0_err, m1_ack, m1_err, bus_we, bus_re;
  logic [1:0]  grant;

  typedef struct packed {
    logic [1:0]  grant;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } bus_exp_t;

  typedef struct packed {
    logic [1:0]  grant;
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  bus_exp_t    bus_q[$];
  rsp_exp_t    rsp_q[$];
  int          ack_cyc[$];
  int          cyc = 0;
  int          last_ack_cyc = -1, last_strobe_cyc = -1;
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
  bus_exp_t    be;
  rsp_exp_t    re;

  mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wd      (m0_wd),
    .m0_rdata   (m0_rdata),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wd      (m1_wd),
    .m1_rdata   (m1_rdata),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .bus_address(bus_address),
    .bus_wd     (bus_wd),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rd     (bus_rd),
    .grant      (grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: one well-known word, everything else derived from the address
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h0040_0008) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic is_mapped(input logic [31:0] a);
    return (a >= 32'h0040_0000 && a < 32'h1001_0020) ||
           (a >= 32'h1001_0020 && a < 32'h1001_0040);
  endfunction

  always_comb bus_rd = rd_model(bus_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares every strobe and every ack against the scoreboard queues
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd0 = '0;
      exp_rd1 = '0;
    end else begin
      if (bus_we || bus_re) begin
        last_strobe_cyc = cyc;
        if (bus_q.size() == 0) flag("unexpected_strobe");
        else begin
          be = bus_q.pop_front();
          check("bus_we", bus_we, be.we);
          check("bus_re", bus_re, !be.we);
          check("bus_address", bus_address, be.addr);
          if (be.we) check("bus_wd", bus_wd, be.wd);
          check("strobe_grant", grant, be.grant);
        end
      end
      if (m0_ack || m1_ack) begin
        last_ack_cyc = cyc;
        ack_cyc.push_back(cyc);
        if (rsp_q.size() == 0) flag("unexpected_ack");
        else begin
          re = rsp_q.pop_front();
          check("ack_pattern", {m1_ack, m0_ack}, re.grant);
          check("ack_grant", grant, re.grant);
          if (re.grant[0]) begin
            check("m0_rdata", m0_rdata, re.rdata);
            check("m0_err", m0_err, re.err);
            check("m1_err_idle", m1_err, 0);
            check("m1_rdata_hold", m1_rdata, exp_rd1);
            exp_rd0 = re.rdata;
          end else begin
            check("m1_rdata", m1_rdata, re.rdata);
            check("m1_err", m1_err, re.err);
            check("m0_err_idle", m0_err, 0);
            check("m0_rdata_hold", m0_rdata, exp_rd0);
            exp_rd1 = re.rdata;
          end
        end
      end
    end
  end

  task automatic push_exp(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
    bus_exp_t b;
    rsp_exp_t r;
    logic [1:0] g;
    g = (m == 0) ? 2'b01 : 2'b10;
    if (is_mapped(addr)) begin
      b = '{grant: g, we: we, addr: addr, wd: wd};
      bus_q.push_back(b);
    end
    r = '{grant: g, rdata: is_mapped(addr) ? rd_model(addr) : 32'h0, err: !is_mapped(addr)};
    rsp_q.push_back(r);
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wd = wd;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wd = wd;
    end
  endtask

  task automatic wait_ack(input int m, output logic got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) got = 1'b1;
    end
    if (!got) flag($sformatf("ack_timeout_m%0d", m));
  endtask

  task automatic run_one(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
    int   issue;
    logic got;
    push_exp(m, we, addr, wd);
    @(posedge clk); #1;
    drive(m, 1'b1, we, addr, wd);
    issue = cyc;
    wait_ack(m, got);
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    if (got) begin
      check("ack_latency", last_ack_cyc, issue + 2);
      if (is_mapped(addr)) check("strobe_latency", last_strobe_cyc, issue + 1);
    end
  endtask

  // Keeps req high across n back-to-back transactions
  task automatic master_seq(input int m, input int n, input logic we, input logic [31:0] base,
                            input logic [31:0] wbase);
    logic got;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      drive(m, 1'b1, we, base + 32'(4 * i), wbase + 32'(i));
      wait_ack(m, got);
      @(posedge clk); #1;
    end
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_bus_we"}, bus_we, 0);
    check({tag, "_bus_re"}, bus_re, 0);
    check({tag, "_bus_address"}, bus_address, 0);
    check({tag, "_bus_wd"}, bus_wd, 0);
    check({tag, "_acks"}, {m1_ack, m0_ack}, 0);
    check({tag, "_errs"}, {m1_err, m0_err}, 0);
    check({tag, "_m0_rdata"}, m0_rdata, 0);
    check({tag, "_m1_rdata"}, m1_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic got0, got1;
    #1;
    check_all_zero("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-ACCESS: m0 read is discarded, pointer returns to 1
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h0040_0010, 32'h0);
    @(posedge clk); #1;
    check("pre_reset_bus_re", bus_re, 1);
    check("pre_reset_grant", grant, 2'b01);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 check_all_zero("async_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_strobes", {bus_we, bus_re}, 0);
      check("idle_grant", grant, 0);
    end

    // Contention: m0 reads, m1 writes, 4 each, strictly alternating from m0
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 1'b0, 32'h0040_0100 + 32'(4 * i), 32'h0);
      push_exp(1, 1'b1, 32'h1001_0020 + 32'(4 * i), 32'h0000_0100 + 32'(i));
    end
    ack_cyc.delete();
    fork
      master_seq(0, 4, 1'b0, 32'h0040_0100, 32'h0);
      master_seq(1, 4, 1'b1, 32'h1001_0020, 32'h0000_0100);
    join
    check("contention_acks", ack_cyc.size(), 8);
    for (int i = 1; i < ack_cyc.size(); i++) check("contention_gap", ack_cyc[i] - ack_cyc[i-1], 3);

    // Single read, UART write, unmapped and boundary addresses
    run_one(0, 1'b0, 32'h0040_0008, 32'h0);
    run_one(1, 1'b1, 32'h1001_0024, 32'h0000_0041);
    run_one(0, 1'b0, 32'h0000_0000, 32'h0);
    run_one(0, 1'b0, 32'h1001_0040, 32'h0);
    run_one(0, 1'b0, 32'h003F_FFFC, 32'h0);
    run_one(1, 1'b0, 32'h1001_003C, 32'h0);
    run_one(0, 1'b0, 32'h0040_0000, 32'h0);
    run_one(1, 1'b0, 32'h1001_001C, 32'h0);

    // Early drop: m1 releases req during ACCESS; m0 arrives then and waits one IDLE
    push_exp(1, 1'b0, 32'h0040_0200, 32'h0);
    push_exp(0, 1'b0, 32'h0040_0300, 32'h0);
    ack_cyc.delete();
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h0040_0200, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h0040_0300, 32'h0);
    wait_ack(1, got1);
    wait_ack(0, got0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("drop_acks", ack_cyc.size(), 2);
    if (ack_cyc.size() == 2) check("drop_gap", ack_cyc[1] - ack_cyc[0], 3);

    repeat (5) @(posedge clk);
    check("bus_q_drained", bus_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single core-side port of the memory-map master (ROM and UART slaves) between the processor data port (master 0) and a second bus master (master 1, e.g. a program loader or DMA). It runs one transaction at a time through a 3-state sequencer with round-robin priority. All bus-side outputs are registered. Unmapped addresses are answered locally with an error response and never reach the slaves.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  transaction request; held high until the matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req is high
- m0_addr / m1_addr  in  ADDR_WIDTH  byte address; stable while req is high
- m0_wd / m1_wd  in  DATA_WIDTH  write data; stable while req is high
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid in the ack cycle
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  unmapped-address flag, valid in the ack cycle
- bus_address  out  ADDR_WIDTH  address to the memory map
- bus_wd  out  DATA_WIDTH  write data to the memory map
- bus_we / bus_re  out  1  write / read strobe to the memory map
- bus_rd  in  DATA_WIDTH  read data from the memory map (combinational)
- grant  out  2  one-hot owner of the current transaction (bit0 = m0), 0 when idle

## Operation
- States: IDLE, ACCESS, RESP. Reset enters IDLE.
- Priority pointer `last`: reset value 1, which gives m0 priority on the first contention.
- IDLE handling:
  - Only m0_req: grant m0.
  - Only m1_req: grant m1.
  - Both: grant the master not equal to `last`.
  - Neither: stay in IDLE.
  - On a grant: latch addr/we/wd of the winner, update `last`, set grant, go to ACCESS.
- Address decode on the latched address:
  - Mapped = [0x0040_0000, 0x1001_0020) (ROM) or [0x1001_0020, 0x1001_0040) (UART).
  - Everything else is unmapped.
- ACCESS (exactly one cycle):
  - Mapped: bus_address = latched addr, bus_wd = latched wd, bus_we = we, bus_re = !we. bus_rd is captured into the response register at the end of the cycle (captured for writes as well; ignored there).
  - Unmapped: bus_we = bus_re = 0, response data forced to 0, error flag set.
  - Next state: RESP.
- RESP (one cycle):
  - The granted master sees ack = 1, rdata = captured data, and err.
  - The other master's ack and err stay 0.
  - grant clears and the state returns to IDLE.
- Requesters are not re-arbitrated mid-transaction. A req dropped during ACCESS or RESP does not abort: the transaction completes and the ack is still issued.
- After RESP the arbiter always spends one IDLE cycle before the next grant. Back-to-back requests are therefore re-arbitrated fairly.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE, `last` goes to 1.
  - All outputs go to 0: grant, bus_*, m*_ack, m*_err, m*_rdata.
  - Reset asserted mid-transaction discards that transaction with no ack.
- Latency: req first sampled high at edge N → bus strobes in cycle N+1 → ack in cycle N+2.
- Throughput: one transaction per 3 cycles while a request is pending.
- bus_we and bus_re are high only during ACCESS and never both high. bus_address and bus_wd hold their last value outside ACCESS.
- m*_rdata holds its value after the ack until the next RESP for that master.
- Address compares are unsigned, full ADDR_WIDTH. The bounds are inclusive low, exclusive high.

## Test plan
- Reset then idle: rst_n low mid-ACCESS → all outputs 0 immediately (asynchronous), state IDLE, no ack. After release with no req, bus_we = bus_re = 0 indefinitely.
- Single read: m0 reads 0x0040_0008 with bus_rd = 0xDEAD_BEEF → bus_re = 1 and bus_address = 0x0040_0008 in cycle N+1; m0_ack = 1 and m0_rdata = 0xDEAD_BEEF in N+2; grant = 2'b01 during N+1..N+2.
- Single write to UART: m1 writes 0x1001_0024 with data 0x0000_0041 → bus_we = 1 and bus_wd = 0x41 for exactly one cycle; m1_ack pulses, m1_err = 0.
- Unmapped: m0 reads 0x0000_0000 and then 0x1001_0040 → no bus strobe either time; m0_ack with m0_err = 1 and m0_rdata = 0.
- Contention fairness: both requesters hold req for 4 transactions each → grant order m0, m1, m0, m1, … with acks 3 cycles apart; no master waits more than one transaction.
- Early drop: m1 drops req in its ACCESS cycle → m1_ack still pulses in RESP; m0's pending request is granted in the following IDLE.
